// File: rtl/net_framer_pkg.sv
// Shared types and constants for the link framer.
// NET_FRAMER_CKSUM_EN adds the trailing checksum byte and its FSM state.
package net_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_START,
        ST_HDR_ADDR,
        ST_HDR_SEQ,
        ST_FETCH,
        ST_LOAD,
        ST_PAYLOAD
`ifdef NET_FRAMER_CKSUM_EN
        , ST_CKSUM
`endif
    } state_e;

    localparam logic [7:0] START_BYTE_DEF = 8'h7E;
    localparam int         HDR_LEN        = 3;

    // Bytes on the wire for one frame of the given payload size.
    function automatic int frame_len(input int packet_size);
`ifdef NET_FRAMER_CKSUM_EN
        return HDR_LEN + packet_size + 1;
`else
        return HDR_LEN + packet_size;
`endif
    endfunction

endpackage

// File: rtl/net_cksum.sv
// 8-bit modulo-256 accumulator; clear has priority over add.
module net_cksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= 8'h00;
        end else if (clr_i) begin
            sum_q <= 8'h00;
        end else if (add_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/net_framer.sv
// Drains fixed-size packets from the transport buffer and wraps them in link
// frames. NET_FRAMER_CKSUM_EN appends a checksum byte (sum of addr, seq, payload).
module net_framer
    import net_framer_pkg::*;
#(
    parameter int         PACKET_SIZE = 16,
    parameter logic [7:0] START_BYTE  = START_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bufData,
    input  logic [9:0]  bufCount,
    input  logic        bufEmpty,
    output logic        bufRd,
    input  logic [7:0]  phoneNum,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic [15:0] framesSent
);

    localparam logic [9:0] PKT_CNT  = 10'(PACKET_SIZE);
    localparam logic [7:0] LAST_IDX = 8'(PACKET_SIZE - 1);

    state_e      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  phone_q, phone_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frames_q, frames_d;
    logic        accept;
    logic        frame_done;

`ifdef NET_FRAMER_CKSUM_EN
    logic       cks_clr;
    logic       cks_add;
    logic [7:0] cks_sum;

    // The byte being accepted is added on the same edge, so the checksum byte
    // itself is formed from the pre-add sum plus the outgoing byte.
    net_cksum u_cksum (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cks_clr),
        .add_i  (cks_add),
        .data_i (tx_data_q),
        .sum_o  (cks_sum)
    );
`endif

    assign accept = tx_valid_q && txReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            phone_q    <= 8'h00;
            seq_q      <= 8'h00;
            cnt_q      <= 8'h00;
            frames_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            phone_q    <= phone_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            frames_q   <= frames_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        phone_d    = phone_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        frames_d   = frames_q;
        frame_done = 1'b0;
`ifdef NET_FRAMER_CKSUM_EN
        cks_clr    = 1'b0;
        cks_add    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bufCount >= PKT_CNT && !bufEmpty) begin
                    state_d    = ST_HDR_START;
                    phone_d    = phoneNum;
                    tx_data_d  = START_BYTE;
                    tx_valid_d = 1'b1;
                    cnt_d      = 8'h00;
`ifdef NET_FRAMER_CKSUM_EN
                    cks_clr    = 1'b1;
`endif
                end
            end
            ST_HDR_START: begin
                if (accept) begin
                    state_d   = ST_HDR_ADDR;
                    tx_data_d = phone_q;
                end
            end
            ST_HDR_ADDR: begin
                if (accept) begin
                    state_d   = ST_HDR_SEQ;
                    tx_data_d = seq_q;
`ifdef NET_FRAMER_CKSUM_EN
                    cks_add   = 1'b1;
`endif
                end
            end
            ST_HDR_SEQ: begin
                if (accept) begin
                    state_d    = ST_FETCH;
                    tx_valid_d = 1'b0;
`ifdef NET_FRAMER_CKSUM_EN
                    cks_add    = 1'b1;
`endif
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d    = ST_PAYLOAD;
                tx_data_d  = bufData;
                tx_valid_d = 1'b1;
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 8'h01;
`ifdef NET_FRAMER_CKSUM_EN
                    cks_add = 1'b1;
`endif
                    if (cnt_q != LAST_IDX) begin
                        state_d    = ST_FETCH;
                        tx_valid_d = 1'b0;
                    end else begin
`ifdef NET_FRAMER_CKSUM_EN
                        state_d   = ST_CKSUM;
                        tx_data_d = cks_sum + tx_data_q;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef NET_FRAMER_CKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        if (frame_done) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            seq_d      = seq_q + 8'h01;
            frames_d   = frames_q + 16'h0001;
        end
    end

    assign bufRd      = (state_q == ST_FETCH);
    assign txData     = tx_data_q;
    assign txValid    = tx_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign framesSent = frames_q;

endmodule

// File: tb/tb_net_framer.sv
// Scoreboard bench for net_framer: a transport-buffer model feeds the DUT and
// every accepted link byte is compared against the expected frame queue.
module tb_net_framer;

    localparam int P = 16;
`ifdef NET_FRAMER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int FRAME_CYC = 3 + 3 * P + CK;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  bufData = 8'h00;
    logic [9:0]  bufCount = 10'd0;
    logic        bufEmpty = 1'b1;
    logic        bufRd;
    logic [7:0]  phoneNum = 8'h00;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b0;
    logic        busy;
    logic [15:0] framesSent;

    always #5 clk = ~clk;

    net_framer #(.PACKET_SIZE(P), .START_BYTE(8'h7E)) dut (
        .clk        (clk),
        .reset      (reset),
        .bufData    (bufData),
        .bufCount   (bufCount),
        .bufEmpty   (bufEmpty),
        .bufRd      (bufRd),
        .phoneNum   (phoneNum),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .busy       (busy),
        .framesSent (framesSent)
    );

    int         checks = 0;
    int         fails = 0;
    logic [7:0] buf_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq = 8'h00;
    int         ready_mode = 0;
    int         cyc = 0;
    bit         cnt_ovr = 1'b0;
    logic [9:0] cnt_ovr_val = 10'd0;
    int         rd_pulses = 0;
    int         busy_cyc = 0;
    bit         prev_rd = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1);
    end

    // One clock: drive inputs for the next edge, model the buffer, check outputs.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       txReady = 1'b1;
            1:       txReady = (cyc % 2) == 0;
            default: txReady = 1'b0;
        endcase
        if (bufRd && buf_q.size() > 0) bufData = buf_q.pop_front();
        if (cnt_ovr) bufCount = cnt_ovr_val;
        else bufCount = (buf_q.size() > 1023) ? 10'd1023 : 10'(buf_q.size());
        bufEmpty = (buf_q.size() == 0);

        if (bufRd) begin
            rd_pulses++;
            checks++;
            if (prev_rd) begin
                fails++;
                $display("FAIL bufrd_b2b: bufRd high two cycles running, required single pulses");
            end
        end
        prev_rd = bufRd;
        if (prev_stall) begin
            checks++;
            if (txValid !== 1'b1 || txData !== prev_data) begin
                fails++;
                $display("FAIL stall_hold: txValid=%b txData=%02h, required 1 and %02h", txValid, txData, prev_data);
            end
        end
        prev_stall = txValid && !txReady;
        prev_data  = txData;
        if (busy) busy_cyc++;
        if (txValid && txReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_byte: got %02h, required no byte", txData);
            end else begin
                e = exp_q.pop_front();
                if (txData !== e) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h, required %02h", txData, e);
                end
            end
        end
    endtask

    task automatic load_frame(input logic [7:0] phone, input logic [7:0] base);
        logic [7:0] sum;
        logic [7:0] b;
        sum = phone + exp_seq;
        exp_q.push_back(8'h7E);
        exp_q.push_back(phone);
        exp_q.push_back(exp_seq);
        for (int i = 0; i < P; i++) begin
            b = base + 8'(i);
            buf_q.push_back(b);
            exp_q.push_back(b);
            sum = sum + b;
        end
        if (CK != 0) exp_q.push_back(sum);
        exp_seq = exp_seq + 8'h01;
    endtask

    task automatic run_until_idle(input int budget);
        bit started = 1'b0;
        int n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (busy) started = 1'b1;
            else if (started && buf_q.size() < P) break;
        end
        if (n >= budget) begin
            checks++;
            fails++;
            $display("FAIL run_timeout: no idle within %0d cycles, busy=%b", budget, busy);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        buf_q.delete();
        exp_q.delete();
        exp_seq = 8'h00;
        prev_rd = 1'b0;
        prev_stall = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks += 5;
        if (bufRd !== 1'b0)         begin fails++; $display("FAIL rst_bufRd: %b, required 0", bufRd); end
        if (txValid !== 1'b0)       begin fails++; $display("FAIL rst_txValid: %b, required 0", txValid); end
        if (txData !== 8'h00)       begin fails++; $display("FAIL rst_txData: %02h, required 00", txData); end
        if (busy !== 1'b0)          begin fails++; $display("FAIL rst_busy: %b, required 0", busy); end
        if (framesSent !== 16'h0)   begin fails++; $display("FAIL rst_frames: %0d, required 0", framesSent); end
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        ready_mode = 0;
        phoneNum = 8'h42;
        rd_pulses = 0;
        busy_cyc = 0;
        load_frame(8'h42, 8'h01);
        tick();
        checks++;
        if (txValid !== 1'b0) begin fails++; $display("FAIL start_early: txValid=%b, required 0", txValid); end
        tick();
        checks++;
        if (txValid !== 1'b1) begin fails++; $display("FAIL start_edge: txValid=%b, required 1", txValid); end
        run_until_idle(500);
        checks += 4;
        if (busy_cyc != FRAME_CYC)  begin fails++; $display("FAIL busy_cycles: %0d, required %0d", busy_cyc, FRAME_CYC); end
        if (rd_pulses != P)         begin fails++; $display("FAIL rd_pulses: %0d, required %0d", rd_pulses, P); end
        if (framesSent !== 16'd1)   begin fails++; $display("FAIL frames_basic: %0d, required 1", framesSent); end
        if (exp_q.size() != 0)      begin fails++; $display("FAIL bytes_left: %0d, required 0", exp_q.size()); end
        $display("test_basic done: busy=%0d rd=%0d", busy_cyc, rd_pulses);
    endtask

    task automatic test_stall();
        ready_mode = 1;
        rd_pulses = 0;
        load_frame(8'h42, 8'h01);
        run_until_idle(1000);
        checks += 3;
        if (rd_pulses != P)         begin fails++; $display("FAIL stall_rd: %0d, required %0d", rd_pulses, P); end
        if (framesSent !== 16'd2)   begin fails++; $display("FAIL stall_frames: %0d, required 2", framesSent); end
        if (exp_q.size() != 0)      begin fails++; $display("FAIL stall_left: %0d, required 0", exp_q.size()); end
        ready_mode = 0;
        $display("test_stall done");
    endtask

    task automatic test_threshold();
        ready_mode = 0;
        cnt_ovr = 1'b1;
        cnt_ovr_val = 10'd15;
        load_frame(8'h42, 8'h20);
        repeat (100) begin
            tick();
            checks++;
            if (txValid !== 1'b0 || bufRd !== 1'b0) begin
                fails++;
                $display("FAIL below_thresh: txValid=%b bufRd=%b, required 0 0", txValid, bufRd);
            end
        end
        cnt_ovr_val = 10'd16;
        tick();
        checks++;
        if (txValid !== 1'b0) begin fails++; $display("FAIL thresh_early: txValid=%b, required 0", txValid); end
        tick();
        checks++;
        if (txValid !== 1'b1) begin fails++; $display("FAIL thresh_start: txValid=%b, required 1", txValid); end
        cnt_ovr = 1'b0;
        run_until_idle(500);
        checks++;
        if (framesSent !== 16'd3) begin fails++; $display("FAIL thresh_frames: %0d, required 3", framesSent); end
        $display("test_threshold done");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        phoneNum = 8'h42;
        for (int f = 0; f < 257; f++) load_frame(8'h42, 8'(f * 3));
        run_until_idle(20000);
        checks += 2;
        if (framesSent !== 16'd257) begin fails++; $display("FAIL b2b_frames: %0d, required 257", framesSent); end
        if (exp_q.size() != 0)      begin fails++; $display("FAIL b2b_left: %0d, required 0", exp_q.size()); end
        $display("test_back_to_back done: frames=%0d", framesSent);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ready_mode = 0;
        rd_pulses = 0;
        load_frame(8'h42, 8'h50);
        while (n < 200 && !(rd_pulses == 5 && txValid)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin fails++; $display("FAIL mid_reach: payload byte 5 not reached, rd=%0d", rd_pulses); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (txValid !== 1'b0)     begin fails++; $display("FAIL mid_txValid: %b, required 0", txValid); end
        if (bufRd !== 1'b0)       begin fails++; $display("FAIL mid_bufRd: %b, required 0", bufRd); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL mid_busy: %b, required 0", busy); end
        if (framesSent !== 16'd0) begin fails++; $display("FAIL mid_frames: %0d, required 0", framesSent); end
        buf_q.delete();
        exp_q.delete();
        exp_seq = 8'h00;
        prev_rd = 1'b0;
        prev_stall = 1'b0;
        tick();
        reset = 1'b1;
        load_frame(8'h42, 8'h60);
        run_until_idle(500);
        checks += 2;
        if (framesSent !== 16'd1) begin fails++; $display("FAIL mid_after: %0d, required 1", framesSent); end
        if (exp_q.size() != 0)    begin fails++; $display("FAIL mid_left: %0d, required 0", exp_q.size()); end
        $display("test_reset_mid done");
    endtask

    task automatic test_phone_change();
        int n = 0;
        int sz;
        ready_mode = 0;
        phoneNum = 8'h42;
        load_frame(8'h42, 8'h70);
        sz = exp_q.size();
        while (n < 50 && exp_q.size() > sz - 3) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin fails++; $display("FAIL phone_reach: HDR_SEQ not reached, left=%0d", exp_q.size()); end
        phoneNum = 8'h55;
        load_frame(8'h55, 8'h80);
        run_until_idle(1000);
        checks += 2;
        if (framesSent !== 16'd3) begin fails++; $display("FAIL phone_frames: %0d, required 3", framesSent); end
        if (exp_q.size() != 0)    begin fails++; $display("FAIL phone_left: %0d, required 0", exp_q.size()); end
        $display("test_phone_change done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_threshold();
        test_back_to_back();
        test_reset_mid();
        test_phone_change();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/net_framer.md
# net_framer

Downstream stage of the transport path: drains the transport layer's outgoing byte buffer one fixed-size packet at a time. It wraps each packet in a link frame: start byte, destination phone number, sequence number, payload, and an optional checksum. It presents the frame bytes to the physical link over a valid/ready byte handshake. It is the only reader of the transport buffer's read strobe.

## Interface
Parameters:
- PACKET_SIZE, 16, payload bytes per frame; matches the transport packet size; legal range 1..255.
- START_BYTE, 8'h7E, frame delimiter sent first in every frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- bufData  in  8  transport buffer read data; valid the cycle after bufRd.
- bufCount  in  10  bytes currently held in the transport buffer.
- bufEmpty  in  1  transport buffer empty.
- bufRd  out  1  read strobe to the transport buffer; exactly one byte per high cycle.
- phoneNum  in  8  destination number from the transport layer; sampled at frame start.
- txData  out  8  frame byte to the link.
- txValid  out  1  txData holds a byte.
- txReady  in  1  link accepts the byte when txValid && txReady.
- busy  out  1  high whenever the FSM is not IDLE.
- framesSent  out  16  count of completed frames; wraps 0xFFFF->0.

## Operation
- Reset values:
  - bufRd=0, txValid=0, txData=0, busy=0, framesSent=0.
  - Internal state: sequence register=0, checksum=0, FSM=IDLE.
- FSM states: IDLE, HDR_START, HDR_ADDR, HDR_SEQ, FETCH, LOAD, PAYLOAD, CKSUM.
- IDLE -> HDR_START when bufCount >= PACKET_SIZE and !bufEmpty.
  - On this transition: latch phoneNum, clear checksum, load txData=START_BYTE, set txValid=1.
- HDR_START -> HDR_ADDR on accept; txData=latched phoneNum.
- HDR_ADDR -> HDR_SEQ on accept; txData=sequence register.
- HDR_SEQ -> FETCH on accept; txValid=0.
- FETCH: bufRd=1 for exactly one cycle (combinational from state), then go to LOAD.
- LOAD: capture bufData into txData, set txValid=1, then go to PAYLOAD.
- PAYLOAD on accept:
  - If the payload byte count is below PACKET_SIZE, go to FETCH.
  - Otherwise go to CKSUM, or finish the frame when the checksum is compiled out.
- CKSUM: txData=checksum; on accept, finish the frame.
- Finishing a frame (same edge as the final accept): increment the sequence register (8-bit, 255->0), increment framesSent, return to IDLE with txValid=0.
- Checksum: 8-bit sum mod 256 of phoneNum, sequence, and all payload bytes, accumulated on each accept. START_BYTE is excluded.
- Handshake rules:
  - While txValid && !txReady, txData is stable and txValid stays high.
  - txValid never drops without an accept, except on reset.
- Boundary conditions:
  - bufEmpty asserting in FETCH is an upstream contract violation; bufRd is still issued and no recovery is attempted.
  - phoneNum changing mid-frame has no effect; the latched value is used.
  - bufCount changing mid-frame has no effect; the start decision is taken only in IDLE.
- Reset mid-frame: return immediately to the reset values; a partial frame is abandoned and the sequence restarts at 0.

## Timing
- txValid rises on the clock edge that samples the start condition in IDLE.
- With txReady held high:
  - Each header byte takes 1 cycle.
  - Each payload byte takes 3 cycles (FETCH, LOAD, PAYLOAD).
  - The checksum takes 1 cycle.
  - Default frame length is 3 + 3·16 + 1 = 52 cycles.
- At least one IDLE cycle separates frames.
- bufRd pulses are never back-to-back; at most PACKET_SIZE pulses per frame.

## Configuration
- NET_FRAMER_CKSUM_EN defined: CKSUM state present; frame is PACKET_SIZE+4 bytes.
- NET_FRAMER_CKSUM_EN undefined: no CKSUM state and no checksum register; the frame ends after the last payload byte and is PACKET_SIZE+3 bytes.

## Structure
- Shared package:
  - FSM state enumeration.
  - Default START_BYTE value.
  - Header length constant (3).
  - Frame length function of PACKET_SIZE and the macro.
- One sub-module, net_cksum: 8-bit accumulator with clear and add-enable inputs. It is instantiated only under NET_FRAMER_CKSUM_EN.

## Test plan
- Preload buffer with bytes 0x01..0x10, phoneNum=0x42, txReady=1 -> frame 7E 42 00 01..10 CS. CS = (0x42 + 0x00 + 0x88) mod 256 = 0xCA. framesSent=1, 16 bufRd pulses, 52 busy cycles.
- Same stimulus with txReady toggling 1-0-1-0 -> identical byte sequence; txData stable through every stall cycle.
- bufCount=15 held for 100 cycles -> no txValid, no bufRd; set count to 16 -> frame starts on the next edge.
- 257 back-to-back frames -> sequence byte 0x00 in frame 257 (wrap); framesSent=257.
- Assert reset during payload byte 5 -> txValid=0 and bufRd=0 immediately; the next frame carries sequence 0x00.
- Change phoneNum 0x42->0x55 during HDR_SEQ -> the current frame keeps 0x42; the next frame carries 0x55.
